req_issue_unit: RTL
===================

Name: req_issue_unit

Overview:
- Initiator side of the execution-unit request/response protocol.
- Accepts add/mul commands from a host valid/ready port and assigns each one a 3-bit request ID from an 8-entry tag pool.
- Drives one req_pkt_type per command into the execution unit, honouring fifo_full.
- Collects out-of-order rsp_pkt_type responses by ID in a reorder buffer and returns results to the host in original command order.

Parameters:
- NUM_TAGS, 8, outstanding-request capacity; equals 2^ID_W.
- ID_W, 3, request/response ID width; matches req_id/rsp_id.
- DATA_W, 32, operand width of req_data1/req_data2.
- RSP_W, 64, result width of rsp_data.

Ports:
- clk  in  1  clock.
- rst_b  in  1  synchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_type  in  1  1 = mul, 0 = add.
- cmd_data1  in  DATA_W  operand 1.
- cmd_data2  in  DATA_W  operand 2.
- output_req  out  req_pkt_type  fields req, req_type, req_id, req_data1, req_data2; to execution unit input_req.
- fifo_full  in  1  execution-unit input FIFO full.
- input_rsp  in  rsp_pkt_type  fields rsp, rsp_id, rsp_data; from execution unit output_rsp.
- res_valid  out  1  in-order result available.
- res_ready  in  1  host accepts result.
- res_id  out  ID_W  tag of the presented result.
- res_type  out  1  op type of the presented result.
- res_data  out  RSP_W  result value.
- outstanding  out  ID_W+1  tags allocated and not yet retired (0..8).
- err_unexp_rsp  out  1  sticky: response received for a tag not awaiting one.

Behaviour:
- Reset (rst_b = 0 at a clk edge) clears:
  - all outputs to 0;
  - head and tail pointers to 0;
  - every ROB entry's busy/done bits;
  - the issue register.
  - Reset mid-operation discards all in-flight state. Responses arriving after reset for old IDs set err_unexp_rsp.
- Tag allocation:
  - Tags are allocated in order: new tag = tail, tail wraps 7 -> 0.
  - Accept requires all of: cmd_valid, cmd_ready, outstanding < NUM_TAGS, and the issue register empty or draining this cycle.
  - cmd_ready = (outstanding != NUM_TAGS) && (!issue_vld || issue_fire).
- Issue register (one entry):
  - Captures type, operands and tag on accept.
  - output_req.req = issue_vld && !fifo_full (combinational gate on fifo_full only); issue_fire = that condition.
  - req_type, req_id and data are always driven from the issue register. They are 0 when issue_vld = 0.
  - A command accepted at edge N appears on output_req from cycle N+1. It holds while fifo_full = 1, with no drops and no duplicates.
  - Back-to-back accept/issue sustains 1 request per cycle.
- ROB (NUM_TAGS entries indexed by tag):
  - Fields: busy, done, type, data.
  - busy is set on accept. done is set when input_rsp.rsp = 1 and rsp_id hits a busy && !done entry; rsp_data is stored at that edge.
  - A response to a not-busy or already-done tag sets err_unexp_rsp, and the entry is left unchanged. err_unexp_rsp is cleared only by reset.
  - A response arriving while its request is still in the issue register (not yet fired) counts as unexpected.
- Retire:
  - res_valid = busy[head] && done[head]. res_* are driven from entry head.
  - A result presented by res_valid is visible no earlier than the cycle after the response edge; minimum latency is rsp edge -> res_valid next cycle.
  - On res_valid && res_ready: clear the entry and advance head, wrapping 7 -> 0. One retire per cycle maximum.
  - res_* hold stable while res_valid && !res_ready.
- outstanding:
  - +1 on accept, -1 on retire; unchanged when both happen in the same cycle.
  - Full = 8: cmd_ready = 0 until a retire. Accept in the same cycle as a retire at full is not allowed (cmd_ready is from registered count).
- Simultaneous events:
  - Accept, issue, response capture and retire may all occur in one cycle on distinct entries.
  - The retiring entry's response cannot be in the same cycle (done must already be set).
- Arithmetic: counts are unsigned. Pointers are ID_W bits with natural wrap. No overflow beyond NUM_TAGS is possible.

Test Plan:
- Single add: cmd(type=0, 5, 7) -> output_req.req=1 next cycle, req_id=0; drive rsp(id=0, data=12) -> res_valid next cycle with res_id=0, res_type=0, res_data=12; outstanding 1 -> 0.
- Back-pressure: fifo_full=1 for 4 cycles after accept -> output_req.req=0 throughout, fields held, cmd_ready=0; release -> exactly one req issued, then cmd_ready=1.
- Reorder: issue ids 0,1,2 (add, mul, add); respond in order 2,0,1 -> results retired strictly in order 0,1,2 with their matching data; res_valid=0 until id 0's response arrives.
- Full/wrap: issue 8 commands with no responses -> outstanding=8, cmd_ready=0; respond and retire id 0 -> the next accepted command gets req_id=0 (wrap); hold res_ready=0 -> res_* stable.
- Error: rsp(id=5) while tag 5 is idle -> err_unexp_rsp=1 and stays 1, ROB unchanged; duplicate rsp to a done tag -> same behaviour.
- Reset mid-flight: 3 outstanding, assert rst_b=0 one cycle -> all outputs 0, outstanding=0; late rsp(id=1) -> err_unexp_rsp=1.

Source files
------------

// File: rtl/req_issue_unit_if.sv
// Host command/result, execution-unit request/response and status bundle for req_issue_unit.
// The DUT side connects through modport master; the host/execution-unit model uses slave.
interface req_issue_unit_if #(
   parameter int ID_W   = 3,
   parameter int DATA_W = 32,
   parameter int RSP_W  = 64
) ();

   typedef struct packed {
      logic              req;
      logic              req_type;
      logic [ID_W-1:0]   req_id;
      logic [DATA_W-1:0] req_data1;
      logic [DATA_W-1:0] req_data2;
   } req_pkt_type;

   typedef struct packed {
      logic             rsp;
      logic [ID_W-1:0]  rsp_id;
      logic [RSP_W-1:0] rsp_data;
   } rsp_pkt_type;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_type;
   logic [DATA_W-1:0] cmd_data1;
   logic [DATA_W-1:0] cmd_data2;
   req_pkt_type       output_req;
   logic              fifo_full;
   rsp_pkt_type       input_rsp;
   logic              res_valid;
   logic              res_ready;
   logic [ID_W-1:0]   res_id;
   logic              res_type;
   logic [RSP_W-1:0]  res_data;
   logic [ID_W:0]     outstanding;
   logic              err_unexp_rsp;

   modport master (
      input  cmd_valid, cmd_type, cmd_data1, cmd_data2, fifo_full, input_rsp, res_ready,
      output cmd_ready, output_req, res_valid, res_id, res_type, res_data, outstanding,
             err_unexp_rsp
   );

   modport slave (
      output cmd_valid, cmd_type, cmd_data1, cmd_data2, fifo_full, input_rsp, res_ready,
      input  cmd_ready, output_req, res_valid, res_id, res_type, res_data, outstanding,
             err_unexp_rsp
   );

endinterface

// File: rtl/req_issue_unit.sv
// Request initiator: tags host commands from an in-order pool, issues them through a one-entry
// register, and reorders out-of-order responses so results return in command order.
module req_issue_unit #(
   parameter int NUM_TAGS = 8,
   parameter int ID_W     = 3,
   parameter int DATA_W   = 32,
   parameter int RSP_W    = 64
) (
   input logic           clk,
   input logic           rst_b,
   req_issue_unit_if.master bus
);

   localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(NUM_TAGS);

   logic [ID_W-1:0]   r_head;
   logic [ID_W-1:0]   r_tail;
   logic [ID_W:0]     r_count;
   logic              r_err;

   logic              r_issue_vld;
   logic              r_issue_type;
   logic [ID_W-1:0]   r_issue_id;
   logic [DATA_W-1:0] r_issue_d1;
   logic [DATA_W-1:0] r_issue_d2;

   logic [NUM_TAGS-1:0] r_busy;
   logic [NUM_TAGS-1:0] r_done;
   logic [NUM_TAGS-1:0] r_type;
   logic [RSP_W-1:0]    r_data [NUM_TAGS];

   logic            w_issue_fire;
   logic            w_cmd_ready;
   logic            w_accept;
   logic            w_res_valid;
   logic            w_retire;
   logic [ID_W-1:0] w_rsp_id;
   logic            w_rsp_hit;
   logic            w_rsp_bad;

   assign w_issue_fire = r_issue_vld && !bus.fifo_full;
   // Held low during reset so every output reads 0 while rst_b is asserted.
   assign w_cmd_ready  = rst_b && (r_count != FULL_CNT) && (!r_issue_vld || w_issue_fire);
   assign w_accept     = bus.cmd_valid && w_cmd_ready;
   assign w_res_valid  = r_busy[r_head] && r_done[r_head];
   assign w_retire     = w_res_valid && bus.res_ready;

   // A tag still sitting unfired in the issue register cannot legitimately be answered yet.
   assign w_rsp_id  = bus.input_rsp.rsp_id;
   assign w_rsp_hit = bus.input_rsp.rsp && r_busy[w_rsp_id] && !r_done[w_rsp_id]
                      && !(r_issue_vld && (r_issue_id == w_rsp_id));
   assign w_rsp_bad = bus.input_rsp.rsp && !w_rsp_hit;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) r_tail <= r_tail + 1'b1;
         if (w_retire) r_head <= r_head + 1'b1;
         if (w_rsp_bad) r_err <= 1'b1;
         unique case ({w_accept, w_retire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_issue_vld  <= 1'b0;
         r_issue_type <= 1'b0;
         r_issue_id   <= '0;
         r_issue_d1   <= '0;
         r_issue_d2   <= '0;
      end else if (w_accept) begin
         r_issue_vld  <= 1'b1;
         r_issue_type <= bus.cmd_type;
         r_issue_id   <= r_tail;
         r_issue_d1   <= bus.cmd_data1;
         r_issue_d2   <= bus.cmd_data2;
      end else if (w_issue_fire) begin
         r_issue_vld  <= 1'b0;
      end
   end

   // Accept, retire and response capture always target distinct entries.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_busy <= '0;
         r_done <= '0;
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            if (w_accept && (r_tail == ID_W'(i))) begin
               r_busy[i] <= 1'b1;
               r_done[i] <= 1'b0;
            end else if (w_retire && (r_head == ID_W'(i))) begin
               r_busy[i] <= 1'b0;
               r_done[i] <= 1'b0;
            end else if (w_rsp_hit && (w_rsp_id == ID_W'(i))) begin
               r_done[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept)  r_type[r_tail]   <= bus.cmd_type;
      if (w_rsp_hit) r_data[w_rsp_id] <= bus.input_rsp.rsp_data;
   end

   assign bus.cmd_ready            = w_cmd_ready;
   assign bus.output_req.req       = w_issue_fire;
   assign bus.output_req.req_type  = r_issue_vld ? r_issue_type : 1'b0;
   assign bus.output_req.req_id    = r_issue_vld ? r_issue_id : '0;
   assign bus.output_req.req_data1 = r_issue_vld ? r_issue_d1 : '0;
   assign bus.output_req.req_data2 = r_issue_vld ? r_issue_d2 : '0;

   assign bus.res_valid     = w_res_valid;
   assign bus.res_id        = w_res_valid ? r_head : '0;
   assign bus.res_type      = w_res_valid ? r_type[r_head] : 1'b0;
   assign bus.res_data      = w_res_valid ? r_data[r_head] : '0;
   assign bus.outstanding   = r_count;
   assign bus.err_unexp_rsp = r_err;

endmodule
